// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge-detection capture path:
// capture FSM state encoding, default frame geometry, pixel width and
// default edge threshold.
package sobel_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned DEF_IMG_W  = 128;
  localparam int unsigned DEF_IMG_H  = 128;
  localparam int unsigned DEF_ADDR_W = 14;

  localparam logic [PIX_W-1:0] DEF_EDGE_THRESH = 8'd100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sobel_frame_capture_raster_counter.sv
// raster_counter: column/row/linear-address generator for raster-order
// frame writes. 'clear' has priority over 'advance'. 'last' is
// combinational and high while the counters sit on the final pixel of
// the frame; advancing from there wraps everything back to 0.
module raster_counter #(
  parameter int unsigned IMG_W  = 4,
  parameter int unsigned IMG_H  = 2,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic [ADDR_W-1:0]        addr,
  output logic                     last
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Final raster position of the frame
  always_comb begin
    last = (col_q == COL_MAX) && (row_q == ROW_MAX);
  end

  // Next counter values: clear, wrap at end of frame, or step one pixel
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      if (last) begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end else if (col_q == COL_MAX) begin
        col_d  = '0;
        row_d  = row_q + ROW_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // Counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/sobel_frame_capture.sv
// sobel_frame_capture: armed, per-frame sink that writes the Sobel
// accelerator output stream into a single-port frame buffer in raster
// order, with a one-cycle frame_done pulse and a sticky overflow flag
// for pixels arriving outside a capture.
// Optional statistics (edge_count / max_mag) are built only when the
// macro SOBEL_CAP_STATS_EN is defined; otherwise those outputs are 0.
module sobel_frame_capture
  import sobel_pkg::*;
#(
  parameter int unsigned       IMG_W       = DEF_IMG_W,
  parameter int unsigned       IMG_H       = DEF_IMG_H,
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [PIX_W-1:0]  EDGE_THRESH = DEF_EDGE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              pixel_out_valid,
  input  logic [PIX_W-1:0]  pixel_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   edge_count,
  output logic [PIX_W-1:0]  max_mag
);

  cap_state_e state_q, state_d;

  logic arm_ok;
  logic accept;

  logic [$clog2(IMG_W)-1:0] unused_col;
  logic [$clog2(IMG_H)-1:0] unused_row;
  logic [ADDR_W-1:0]        cnt_addr;
  logic                     cnt_last;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  // arm is only honoured outside CAPTURE; pixels are only taken in CAPTURE
  assign arm_ok = arm && (state_q != CAPTURE);
  assign accept = pixel_out_valid && (state_q == CAPTURE);

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (arm_ok),
    .advance (accept),
    .col     (unused_col),
    .row     (unused_row),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (accept && cnt_last) state_d = DONE;
      DONE:    state_d = arm ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; status outputs follow the next state so that
  // busy/frame_done line up with the registered write of the last pixel
  always_comb begin
    busy_d       = (state_d == CAPTURE);
    frame_done_d = (state_d == DONE);
    mem_we_d     = accept;
    mem_addr_d   = accept ? cnt_addr  : mem_addr_q;
    mem_wdata_d  = accept ? pixel_out : mem_wdata_q;
    overflow_d   = overflow_q;
    if (arm_ok) begin
      overflow_d = 1'b0;
    end else if (pixel_out_valid && (state_q != CAPTURE)) begin
      overflow_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

`ifdef SOBEL_CAP_STATS_EN
  logic [ADDR_W:0]  edge_count_q, edge_count_d;
  logic [PIX_W-1:0] max_mag_q, max_mag_d;

  // Per-frame statistics over accepted pixels, cleared by an accepted arm
  always_comb begin
    edge_count_d = edge_count_q;
    max_mag_d    = max_mag_q;
    if (arm_ok) begin
      edge_count_d = '0;
      max_mag_d    = '0;
    end else if (accept) begin
      if (pixel_out > EDGE_THRESH) begin
        edge_count_d = edge_count_q + (ADDR_W+1)'(1);
      end
      if (pixel_out > max_mag_q) begin
        max_mag_d = pixel_out;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_count_q <= '0;
      max_mag_q    <= '0;
    end else begin
      edge_count_q <= edge_count_d;
      max_mag_q    <= max_mag_d;
    end
  end

  assign edge_count = edge_count_q;
  assign max_mag    = max_mag_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^EDGE_THRESH;
  assign edge_count    = '0;
  assign max_mag       = '0;
`endif

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Directed bench for sobel_frame_capture with a write scoreboard
// (IMG_W=4, IMG_H=2). Define SOBEL_CAP_STATS_EN to exercise the stats.
module tb_sobel_frame_capture;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned AW   = 3;
  localparam int unsigned NPIX = W * H;

`ifdef SOBEL_CAP_STATS_EN
  localparam logic [31:0] EXP_EDGES = 32'd4;
  localparam logic [31:0] EXP_MAX   = 32'd255;
`else
  localparam logic [31:0] EXP_EDGES = 32'd0;
  localparam logic [31:0] EXP_MAX   = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          pv  = 1'b0;
  logic [7:0]    px  = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [AW:0]   edge_count;
  logic [7:0]    max_mag;

  sobel_frame_capture #(
    .IMG_W       (W),
    .IMG_H       (H),
    .ADDR_W      (AW),
    .EDGE_THRESH (8'd100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .pixel_out_valid (pv),
    .pixel_out       (px),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .busy            (busy),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .edge_count      (edge_count),
    .max_mag         (max_mag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            done_cnt = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge
  task automatic cyc(input logic a, input logic v, input logic [7:0] p);
    @(negedge clk);
    arm = a;
    pv  = v;
    px  = p;
  endtask

  // Drive a pixel that must be accepted and record its expected write
  task automatic pix(input logic a, input logic [7:0] p);
    cyc(a, 1'b1, p);
    exp_q.push_back(wr_t'{addr: exp_addr, data: p});
    exp_addr = exp_addr + AW'(1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  // Write monitor: every mem_we must match the oldest expected write
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_write observed addr=0x%0h data=0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      check("done_with_last_wr", 32'({mem_we, mem_addr}), 32'({1'b1, AW'(NPIX - 1)}));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int d0;
    logic [7:0] s6 [8];
    s6 = '{8'd50, 8'd101, 8'd200, 8'd100, 8'd255, 8'd0, 8'd120, 8'd99};

    // Reset held low across two rising edges
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    check("rst_max_mag",    32'(max_mag),    32'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back frame 1..8
    cyc(1'b1, 1'b0, 8'h00);
    exp_addr = '0;
    pix(1'b0, 8'd1);
    check("busy_after_arm", 32'(busy), 32'd1);
    for (int i = 2; i <= 8; i++) pix(1'b0, 8'(i));
    cyc(1'b0, 1'b0, 8'h00);
    check("b2b_frame_done", 32'(frame_done), 32'd1);
    check("b2b_busy_in_done", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    check("b2b_done_pulse_end", 32'(frame_done), 32'd0);
    check("b2b_busy_after", 32'(busy), 32'd0);
    check("b2b_no_we_after", 32'(mem_we), 32'd0);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Gapped frame, with an arm during capture that must be ignored
    cyc(1'b1, 1'b0, 8'h00);
    exp_addr = '0;
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(1, 3));
      pix((i == 3) ? 1'b1 : 1'b0, 8'(8'h30 + i));
    end
    cyc(1'b0, 1'b0, 8'h00);
    check("gap_frame_done", 32'(frame_done), 32'd1);
    check("gap_overflow", 32'(overflow), 32'd0);
    idle(2);
    check("gap_queue_drained", 32'(exp_q.size()), 32'd0);
    check("gap_done_count", 32'(done_cnt), 32'd2);

    // Stray pixel with no capture armed
    cyc(1'b0, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_no_write", 32'(mem_we), 32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    check("ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_cleared_by_arm", 32'(overflow), 32'd0);
    check("ovf_rearm_busy", 32'(busy), 32'd1);

    // Partial frame, reset, then a full frame from address 0
    exp_addr = '0;
    for (int i = 1; i <= 5; i++) pix(1'b0, 8'(8'h10 + i));
    @(negedge clk);
    rst = 1'b0;
    pv  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    d0 = done_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    exp_addr = '0;
    for (int i = 0; i < 8; i++) pix(1'b0, 8'(8'hA0 + i));
    // Arm during the DONE cycle starts the next frame directly
    cyc(1'b1, 1'b0, 8'h00);
    check("rearm_frame_done", 32'(frame_done), 32'd1);
    exp_addr = '0;
    pix(1'b0, s6[0]);
    check("rearm_single_done", 32'(done_cnt - d0), 32'd1);
    check("arm_in_done_busy", 32'(busy), 32'd1);

    // Statistics frame
    for (int i = 1; i < 8; i++) pix(1'b0, s6[i]);
    cyc(1'b0, 1'b0, 8'h00);
    check("stats_frame_done", 32'(frame_done), 32'd1);
    check("stats_edge_count", 32'(edge_count), EXP_EDGES);
    check("stats_max_mag", 32'(max_mag), EXP_MAX);
    idle(2);
    check("stats_edge_hold", 32'(edge_count), EXP_EDGES);
    check("stats_max_hold", 32'(max_mag), EXP_MAX);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_cnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_capture.md
# sobel_frame_capture

Stream sink for the edge-detection path: consumes the `pixel_out_valid`/`pixel_out` stream produced by `sobel_accelerator` and writes it in raster order into a single-port output frame buffer. It is armed per frame and generates row, column and linear address counters. It reports completion with a one-cycle pulse and flags pixels that arrive when no capture is armed. It sits between the accelerator output and the result frame memory.

## Interface
- `IMG_W`, 128, pixels per output row (≥2)
- `IMG_H`, 128, rows per output frame (≥2)
- `ADDR_W`, 14, frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `EDGE_THRESH`, 8'd100, edge threshold, used only with `SOBEL_CAP_STATS_EN`

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-low reset
- `arm`  in  1  single-cycle request to capture one frame
- `pixel_out_valid`  in  1  accelerator output pixel valid
- `pixel_out`  in  8  accelerator output magnitude
- `mem_we`  out  1  frame-buffer write enable
- `mem_addr`  out  ADDR_W  write address, row*IMG_W+col
- `mem_wdata`  out  8  write data
- `busy`  out  1  high in CAPTURE
- `frame_done`  out  1  one-cycle completion pulse
- `overflow`  out  1  sticky; a valid pixel arrived while not capturing
- `edge_count`  out  ADDR_W+1  pixels with value > EDGE_THRESH (stats build only)
- `max_mag`  out  8  largest captured value (stats build only)

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - `arm`=1 clears the col/row/addr counters, `overflow` and the stats, then goes to CAPTURE.
  - A valid pixel arriving in the arm cycle is dropped and not flagged.
  - A valid pixel arriving without `arm` sets `overflow`.
- CAPTURE:
  - Each `pixel_out_valid`=1 is accepted. No backpressure; every valid pixel is taken.
  - On acceptance, `col` increments. At `col`=IMG_W-1 it wraps to 0 and `row` increments.
  - `addr` increments by 1 per accepted pixel.
  - `arm` is ignored.
  - Acceptance at `row`=IMG_H-1 and `col`=IMG_W-1 moves the FSM to DONE.
- DONE:
  - Lasts exactly one cycle with `frame_done`=1, then returns to IDLE.
  - A valid pixel arriving in DONE sets `overflow`.
  - `arm` in DONE is honoured like IDLE: counters clear and the next state is CAPTURE.
- Gaps in `pixel_out_valid` are allowed anywhere; the counters hold during gaps.
- Reset, including mid-frame: state IDLE, all counters 0, all outputs 0. Partially written memory is left as is.

## Timing
- Write latency: 1 cycle. Pixel accepted on edge N gives `mem_we`/`mem_addr`/`mem_wdata` registered and valid during cycle N+1.
- `mem_we` is high for exactly one cycle per accepted pixel.
- Back-to-back valids produce back-to-back writes at consecutive addresses.
- The last write and `frame_done` are asserted in the same cycle.
- `busy` rises the cycle after `arm` and falls in the DONE cycle.
- `overflow` is set the cycle after the offending pixel and held until the next accepted `arm`, or until reset.
- All outputs are registered. Reset value of every output is 0.

## Configuration
- `SOBEL_CAP_STATS_EN` defined:
  - `edge_count` increments on each accepted pixel whose value exceeds `EDGE_THRESH`.
  - `max_mag` tracks the maximum accepted value.
  - Both are cleared by an accepted `arm` and hold their value after DONE.
  - Both are updated with the same 1-cycle latency as the writes.
- Undefined: the stats logic is removed and `edge_count`/`max_mag` are tied to 0.

## Structure
- Shared package `sobel_pkg`:
  - capture state enum (IDLE/CAPTURE/DONE)
  - default frame dimensions
  - pixel width constant (8)
  - default edge threshold
- One sub-module, `raster_counter`:
  - parameterised IMG_W/IMG_H/ADDR_W
  - inputs: clear, advance
  - outputs: col, row, addr, last (combinational, high at the final position)
- The FSM, write register and stats stay in the top level.

## Test plan
All scenarios use IMG_W=4, IMG_H=2.
- Reset with `rst`=0 for 2 cycles, then release → all outputs 0, `busy`=0.
- Arm, then 8 consecutive valids with values 1..8:
  - writes at addr 0..7 with data 1..8, one cycle after each valid;
  - `frame_done` high with the addr-7 write;
  - `busy` low the following cycle.
- Arm, then 8 valids with 1–3 idle cycles between them → same addresses and data, no extra writes, `overflow`=0.
- Valid pixel 0x55 with no arm → no write, `overflow`=1 the next cycle; a following `arm` clears it.
- Arm, 5 pixels, assert `rst`=0 for 1 cycle, re-arm, 8 pixels → the second frame writes from addr 0, and exactly one `frame_done` is seen.
- Stats build, EDGE_THRESH=100, pixels 50,101,200,100,255,0,120,99 → `edge_count`=4, `max_mag`=255 after DONE.
